// File: rtl/vga_timing_65.sv
// 1024x768@60 VESA timing generator for the 65 MHz pixel clock; outputs are registered decodes of hc/vc.
// Define VGA_TIMING_PATTERN_EN to add the 6-bit rgb colour-bar output.
module vga_timing_65 #(
  parameter int   H_VISIBLE = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_VISIBLE = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [5:0]  rgb
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] hc_reg, hc_next;
  logic [9:0]  vc_reg, vc_next;
  logic        hs_next, vs_next, active_next;

  // Decodes look at the counter value held before the edge, giving one cycle of latency to the pins.
  always_comb begin
    hc_next     = (hc_reg == H_LAST) ? 11'd0 : hc_reg + 11'd1;
    vc_next     = vc_reg;
    if (hc_reg == H_LAST) begin
      vc_next = (vc_reg == V_LAST) ? 10'd0 : vc_reg + 10'd1;
    end
    active_next = (hc_reg < H_VIS_END) && (vc_reg < V_VIS_END);
    hs_next     = ((hc_reg >= HS_START) && (hc_reg < HS_END)) ? HS_POL : ~HS_POL;
    vs_next     = ((vc_reg >= VS_START) && (vc_reg < VS_END)) ? VS_POL : ~VS_POL;
  end

`ifdef VGA_TIMING_PATTERN_EN
  logic [2:0] bar_idx;
  logic [5:0] rgb_next;
  assign bar_idx = hc_reg[9:7];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bar
      assign rgb_next[2*gi+1:2*gi] = active_next ? {2{bar_idx[gi]}} : 2'b00;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rgb <= 6'd0;
    end else if (enable) begin
      rgb <= rgb_next;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg      <= 11'd0;
      vc_reg      <= 10'd0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      active      <= 1'b0;
      x           <= 11'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (enable) begin
      hc_reg      <= hc_next;
      vc_reg      <= vc_next;
      hsync       <= hs_next;
      vsync       <= vs_next;
      active      <= active_next;
      x           <= hc_reg;
      y           <= vc_reg;
      line_start  <= (hc_reg == 11'd0);
      frame_start <= (hc_reg == 11'd0) && (vc_reg == 10'd0);
    end else begin
      // Stalled: everything holds except the strobes, so each position pulses only once.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
